// File: rtl/disp_arbiter.sv
// Round-robin arbiter that shares the 16-bit seven-segment display value between
// up to four requesters, with a minimum ownership time counted in display ticks.
module disp_arbiter #(
  parameter int N_REQ      = 4,
  parameter int HOLD_TICKS = 500
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic [N_REQ-1:0]     req,
  input  logic [16*N_REQ-1:0]  data,
  output logic [N_REQ-1:0]     gnt,
  output logic [1:0]           owner,
  output logic [15:0]          seg,
  output logic                 busy
);

  localparam int              CNT_W     = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_TICKS);
  localparam logic [1:0]      OWNER_RST = 2'(N_REQ - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_OWN    = 2'd1;
  localparam logic [1:0] S_SWITCH = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [1:0]       owner_q, owner_d;
  logic [15:0]      seg_q, seg_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  logic             win_vld;
  logic [1:0]       win_idx;
  logic [15:0]      win_data;
  logic [15:0]      own_data;
  logic             own_req;
  logic             others_req;
  logic             expired;

  // Scan from the farthest offset down so the nearest requester after the
  // pointer is the last one written, i.e. the winner.
  always_comb begin
    win_vld = 1'b0;
    win_idx = owner_q;
    for (int off = N_REQ; off >= 1; off--) begin
      if (req[(int'(owner_q) + off) % N_REQ]) begin
        win_vld = 1'b1;
        win_idx = 2'((int'(owner_q) + off) % N_REQ);
      end
    end
  end

  always_comb begin
    own_data = '0;
    own_req  = 1'b0;
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_q == 2'(i)) begin
        own_data = data[16*i +: 16];
        own_req  = req[i];
      end
      if (win_idx == 2'(i)) win_data = data[16*i +: 16];
    end
  end

  assign others_req = |(req & ~gnt_q);
  assign expired    = (hold_cnt_q == HOLD_MAX);

  // NOTE: every next-state signal is given its hold value first so no path
  // through the case statement leaves it unassigned (which would infer a latch).
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    seg_d      = seg_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d    = S_OWN;
          gnt_d      = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
          owner_d    = win_idx;
          seg_d      = win_data;
          hold_cnt_d = '0;
        end
      end
      S_OWN: begin
        seg_d = own_data;
        if (tick && !expired) hold_cnt_d = hold_cnt_q + CNT_W'(1);
        // Voluntary release wins over expiry; either way the pointer stays put.
        if (!own_req || (expired && others_req)) begin
          state_d = S_SWITCH;
          gnt_d   = '0;
        end
      end
      S_SWITCH: state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      owner_q    <= OWNER_RST;
      seg_q      <= 16'h0000;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      seg_q      <= seg_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign seg   = seg_q;
  assign busy  = (state_q == S_OWN);

endmodule

// File: tb/tb_disp_arbiter.sv
// Self-checking bench for disp_arbiter: two instances (hold 3 and hold 0) share
// stimulus and are compared every cycle against a cycle-level behavioural model.
module tb_disp_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic [3:0]  req;
  logic [63:0] data;

  logic [3:0]  gnt3, gnt0;
  logic [1:0]  owner3, owner0;
  logic [15:0] seg3, seg0;
  logic        busy3, busy0;

  always #5 clk = ~clk;

  disp_arbiter #(.N_REQ(4), .HOLD_TICKS(3)) dut3 (
    .clk(clk), .reset(reset), .tick(tick), .req(req), .data(data),
    .gnt(gnt3), .owner(owner3), .seg(seg3), .busy(busy3)
  );

  disp_arbiter #(.N_REQ(4), .HOLD_TICKS(0)) dut0 (
    .clk(clk), .reset(reset), .tick(tick), .req(req), .data(data),
    .gnt(gnt0), .owner(owner0), .seg(seg0), .busy(busy0)
  );

  // Model: who owns (or last owned), ticks seen, and edges still to wait
  // after a release before arbitration is allowed again.
  typedef struct {
    bit          owning;
    int          who;
    int          ticks;
    int          gap;
    logic [15:0] seg;
  } mdl_t;

  mdl_t m3, m0;
  int   tests = 0;
  int   fails = 0;

  logic [3:0] hold0_pat [0:11] = '{4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000,
                                   4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
  int         rr_exp [0:4] = '{0, 1, 2, 3, 0};

  function automatic mdl_t mdl_next(mdl_t m, int hold, bit rst, logic [3:0] rq,
                                    logic [63:0] d, bit tk);
    mdl_t n;
    int   k;
    n = m;
    if (rst) begin
      n.owning = 1'b0; n.who = 3; n.ticks = 0; n.gap = 0; n.seg = 16'h0000;
      return n;
    end
    if (m.owning) begin
      n.seg = d[16*m.who +: 16];
      if (!rq[m.who] || (m.ticks >= hold && (rq & ~(4'b0001 << m.who)) != 4'b0000)) begin
        n.owning = 1'b0;
        n.gap    = 1;
      end else if (tk && m.ticks < hold) begin
        n.ticks = m.ticks + 1;
      end
    end else if (m.gap > 0) begin
      n.gap = m.gap - 1;
    end else if (rq != 4'b0000) begin
      for (int o = 1; o <= 4; o++) begin
        k = (m.who + o) % 4;
        if (rq[k]) begin
          n.owning = 1'b1; n.who = k; n.seg = d[16*k +: 16]; n.ticks = 0;
          break;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m3 = mdl_next(m3, 3, reset, req, data, tick);
    m0 = mdl_next(m0, 0, reset, req, data, tick);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("mdl3_gnt",   gnt3,   m3.owning ? (4'b0001 << m3.who) : 4'b0000);
    check("mdl3_owner", owner3, m3.who);
    check("mdl3_seg",   seg3,   m3.seg);
    check("mdl3_busy",  busy3,  m3.owning);
    check("mdl0_gnt",   gnt0,   m0.owning ? (4'b0001 << m0.who) : 4'b0000);
    check("mdl0_owner", owner0, m0.who);
    check("mdl0_seg",   seg0,   m0.seg);
    check("mdl0_busy",  busy0,  m0.owning);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      compare_all();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] prev;
    int         zero_run;
    int         bad;
    int         order [$];

    reset = 1'b1; tick = 1'b0; req = 4'b0000; data = 64'h0;
    step(1);
    check("rst_gnt", gnt3, 4'b0000);
    check("rst_owner", owner3, 2'd3);
    check("rst_seg", seg3, 16'h0000);
    check("rst_busy", busy3, 1'b0);

    // All four requesting, hold of 3 ticks: strict rotation 0,1,2,3,0.
    reset = 1'b0;
    data  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    req   = 4'b1111;
    step(1);
    check("rr_first_gnt", gnt3, 4'b0001);
    check("rr_first_seg", seg3, 16'h1111);
    tick = 1'b1;
    order.push_back(0);
    prev = gnt3;
    zero_run = 0;
    for (int c = 0; c < 30; c++) begin
      step(1);
      if (gnt3 === 4'b0000) zero_run++;
      else if (prev === 4'b0000) begin
        order.push_back(int'(owner3));
        check("rr_handover_gap", zero_run, 2);
        zero_run = 0;
      end
      prev = gnt3;
    end
    check("rr_order_len", order.size() >= 5, 1'b1);
    for (int i = 0; i < 5; i++)
      if (i < order.size()) check("rr_order", order[i], rr_exp[i]);

    // Sole requester keeps the display indefinitely.
    do_reset();
    data = {$urandom, $urandom};
    data[47:32] = 16'hBEEF;
    req  = 4'b0100;
    tick = 1'b1;
    step(1);
    check("single_gnt", gnt3, 4'b0100);
    check("single_seg", seg3, 16'hBEEF);
    bad = 0;
    for (int c = 0; c < 2000; c++) begin
      step(1);
      if (gnt3 !== 4'b0100 || seg3 !== 16'hBEEF) bad++;
    end
    check("single_hold", bad, 0);

    // Voluntary release before expiry hands over after SWITCH and IDLE.
    do_reset();
    tick = 1'b0;
    req  = 4'b0010;
    step(1);
    check("rel_gnt1", gnt3, 4'b0010);
    req  = 4'b1010;
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    req  = 4'b1000;
    step(1);
    check("rel_switch_gnt", gnt3, 4'b0000);
    check("rel_switch_busy", busy3, 1'b0);
    step(1);
    check("rel_idle_gnt", gnt3, 4'b0000);
    step(1);
    check("rel_next_gnt", gnt3, 4'b1000);
    check("rel_next_owner", owner3, 2'd3);

    // Live data from the owner; non-owner data ignored.
    do_reset();
    data = {16'hAAAA, 16'hBBBB, 16'hCCCC, 16'h1234};
    req  = 4'b0001;
    step(1);
    check("live_seg0", seg3, 16'h1234);
    data[15:0] = 16'h5678;
    step(1);
    check("live_seg1", seg3, 16'h5678);
    data[31:16] = 16'hFFFF;
    step(1);
    check("live_nonowner", seg3, 16'h5678);
    check("live_gnt", gnt3, 4'b0001);

    // Zero hold: one-cycle grants alternating 0,1 with two idle cycles between.
    do_reset();
    req = 4'b0011;
    for (int c = 0; c < 12; c++) begin
      step(1);
      check("hold0_pattern", gnt0, hold0_pat[c]);
    end

    // Reset in the middle of ownership.
    do_reset();
    data = {$urandom, $urandom} | 64'h0001_0001_0001_0001;
    req  = 4'b0100;
    step(1);
    check("midrst_pre_owner", owner3, 2'd2);
    reset = 1'b1;
    step(1);
    check("midrst_gnt", gnt3, 4'b0000);
    check("midrst_seg", seg3, 16'h0000);
    check("midrst_owner", owner3, 2'd3);
    check("midrst_busy", busy3, 1'b0);
    reset = 1'b0;
    req   = 4'b0101;
    step(1);
    check("midrst_regrant", gnt3, 4'b0001);

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) req = 4'($urandom);
      tick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) data = {$urandom, $urandom};
      step(1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
